// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: Gray/binary conversion and synchroniser depth limits.
// The conversion functions work on a 32-bit container. The live width is
// passed as an argument, and bits above it are ignored.
package fifo_pkg;

   localparam int SYNC_STAGES_MIN = 2;
   localparam int SYNC_STAGES_MAX = 4;

   function automatic logic [31:0] width_mask(input int w);
      if (w >= 32) return '1;
      return (32'd1 << w) - 32'd1;
   endfunction

   function automatic logic [31:0] bin2gray(input logic [31:0] b, input int w);
      logic [31:0] bm;
      bm = b & width_mask(w);
      return bm ^ (bm >> 1);
   endfunction

   // The top bit is copied, and each lower bit folds in the one above it.
   // Zeros above the live width make the sweep from bit 31 safe.
   function automatic logic [31:0] gray2bin(input logic [31:0] g, input int w);
      logic [31:0] gm;
      logic [31:0] b;
      gm    = g & width_mask(w);
      b     = '0;
      b[31] = gm[31];
      for (int i = 30; i >= 0; i--) begin
         b[i] = b[i+1] ^ gm[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/controller_wr_param_if.sv
// Write-side bundle of the async FIFO: push/flag handshake, RAM write port,
// and the Gray pointers exchanged with the read domain.
interface controller_wr_param_if #(
   parameter int PTRWIDTH = 4
);
   logic                push;
   logic                clr_ovf;
   logic [PTRWIDTH:0]   afull_level;
   logic [PTRWIDTH:0]   rdptr_gray;
   logic                wen;
   logic [PTRWIDTH-1:0] waddr;
   logic [PTRWIDTH:0]   wrptr_bin;
   logic [PTRWIDTH:0]   wrptr_gray;
   logic [PTRWIDTH:0]   wr_count;
   logic                full;
   logic                almost_full;
   logic                overflow;

   modport master (
      output push, clr_ovf, afull_level, rdptr_gray,
      input  wen, waddr, wrptr_bin, wrptr_gray, wr_count, full, almost_full, overflow
   );

   modport slave (
      input  push, clr_ovf, afull_level, rdptr_gray,
      output wen, waddr, wrptr_bin, wrptr_gray, wr_count, full, almost_full, overflow
   );
endinterface

// File: rtl/sync_ptr.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing clock domains.
// The read-side controller uses the same module for wrptr_gray.
module sync_ptr #(
   parameter int WIDTH  = 5,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_L,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [STAGES-1:0][WIDTH-1:0] chain;

   // Shift the asynchronous pointer through STAGES flops; element 0 is first.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) chain <= '0;
      else          chain <= {chain[STAGES-2:0], d};
   end

   assign q = chain[STAGES-1];
endmodule

// File: rtl/controller_wr_param.sv
// Write-domain controller of the async FIFO. It owns the write pointers and
// synchronises the read pointer. It derives fill count, full, almost-full and
// the sticky overflow flag.
module controller_wr_param
   import fifo_pkg::*;
#(
   parameter int PTRWIDTH    = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 wclk,
   input  logic                 reset_L,
   controller_wr_param_if.slave wr_if
);
   localparam int PW1 = PTRWIDTH + 1;
   // An out-of-range depth is pulled into the legal window instead of
   // building a synchroniser too short to be safe.
   localparam int STG = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN :
                        (SYNC_STAGES > SYNC_STAGES_MAX) ? SYNC_STAGES_MAX : SYNC_STAGES;
   localparam logic [PTRWIDTH:0] DEPTH_V = {1'b1, {PTRWIDTH{1'b0}}};
   localparam logic [PTRWIDTH:0] ONE_V   = {{PTRWIDTH{1'b0}}, 1'b1};

   logic [PTRWIDTH:0] wrptr_bin_q;
   logic [PTRWIDTH:0] wrptr_gray_q;
   logic [PTRWIDTH:0] wrptr_bin_nxt;
   logic [PTRWIDTH:0] wrptr_gray_nxt;
   logic [PTRWIDTH:0] rdptr_sync;
   logic [PTRWIDTH:0] rdptr_bin_s;
   logic [PTRWIDTH:0] wr_count_c;
   logic              full_c;
   logic              wen_c;
   logic              overflow_q;

   sync_ptr #(.WIDTH(PW1), .STAGES(STG)) u_sync_rd (
      .clk     (wclk),
      .reset_L (reset_L),
      .d       (wr_if.rdptr_gray),
      .q       (rdptr_sync)
   );

   // Fill level and flags are derived combinationally from the current registers.
   always_comb begin
      rdptr_bin_s    = PW1'(gray2bin(32'(rdptr_sync), PW1));
      wr_count_c     = wrptr_bin_q - rdptr_bin_s;
      full_c         = (wr_count_c == DEPTH_V);
      wen_c          = wr_if.push & ~full_c;
      wrptr_bin_nxt  = wrptr_bin_q + ONE_V;
      wrptr_gray_nxt = PW1'(bin2gray(32'(wrptr_bin_nxt), PW1));
   end

   // Advance both pointers together on an accepted write so they never disagree.
   always_ff @(posedge wclk or negedge reset_L) begin
      if (!reset_L) begin
         wrptr_bin_q  <= '0;
         wrptr_gray_q <= '0;
      end else if (wen_c) begin
         wrptr_bin_q  <= wrptr_bin_nxt;
         wrptr_gray_q <= wrptr_gray_nxt;
      end
   end

   // Sticky overflow: a push against full sets it, and a set beats a same-cycle clear.
   always_ff @(posedge wclk or negedge reset_L) begin
      if (!reset_L)                  overflow_q <= 1'b0;
      else if (wr_if.push && full_c) overflow_q <= 1'b1;
      else if (wr_if.clr_ovf)        overflow_q <= 1'b0;
   end

   assign wr_if.wen         = wen_c;
   assign wr_if.waddr       = wrptr_bin_q[PTRWIDTH-1:0];
   assign wr_if.wrptr_bin   = wrptr_bin_q;
   assign wr_if.wrptr_gray  = wrptr_gray_q;
   assign wr_if.wr_count    = wr_count_c;
   assign wr_if.full        = full_c;
   assign wr_if.almost_full = (wr_if.afull_level != '0) && (wr_count_c >= wr_if.afull_level);
   assign wr_if.overflow    = overflow_q;
endmodule

// File: tb/tb_controller_wr_param.sv
// Directed bench for controller_wr_param. Two instances (2 and 3 synchroniser
// stages) see identical stimulus.
module tb_controller_wr_param;
   localparam int PW = 4;

   logic wclk    = 1'b0;
   logic reset_L = 1'b0;
   int   n_cmp   = 0;
   int   n_bad   = 0;

   controller_wr_param_if #(.PTRWIDTH(PW)) ifa ();
   controller_wr_param_if #(.PTRWIDTH(PW)) ifb ();

   assign ifb.push        = ifa.push;
   assign ifb.clr_ovf     = ifa.clr_ovf;
   assign ifb.afull_level = ifa.afull_level;
   assign ifb.rdptr_gray  = ifa.rdptr_gray;

   controller_wr_param #(.PTRWIDTH(PW), .SYNC_STAGES(2)) dut_a (
      .wclk    (wclk),
      .reset_L (reset_L),
      .wr_if   (ifa.slave)
   );

   controller_wr_param #(.PTRWIDTH(PW), .SYNC_STAGES(3)) dut_b (
      .wclk    (wclk),
      .reset_L (reset_L),
      .wr_if   (ifb.slave)
   );

   always #5 wclk = ~wclk;

   task automatic tick;
      @(posedge wclk);
      #1;
   endtask

   task automatic test_reset;
      ifa.push        = 1'b0;
      ifa.clr_ovf     = 1'b0;
      ifa.afull_level = 5'd12;
      ifa.rdptr_gray  = 5'd0;
      #22;
      n_cmp++; if (ifa.wrptr_bin !== 5'd0)  begin n_bad++; $display("FAIL reset_wrptr_bin got %0d want 0", ifa.wrptr_bin); end
      n_cmp++; if (ifa.wrptr_gray !== 5'd0) begin n_bad++; $display("FAIL reset_wrptr_gray got %0d want 0", ifa.wrptr_gray); end
      n_cmp++; if (ifa.wr_count !== 5'd0)   begin n_bad++; $display("FAIL reset_wr_count got %0d want 0", ifa.wr_count); end
      n_cmp++; if ({ifa.full, ifa.wen, ifa.almost_full, ifa.overflow} !== 4'b0000)
         begin n_bad++; $display("FAIL reset_flags got %b want 0000", {ifa.full, ifa.wen, ifa.almost_full, ifa.overflow}); end
      reset_L = 1'b1;
      tick();
   endtask

   // Fill from empty with afull_level 12; also exercises almost-full thresholds.
   task automatic test_fill;
      logic [4:0] e;
      for (int i = 0; i < 16; i++) begin
         ifa.push = 1'b1;
         #1;
         n_cmp++; if (ifa.wen !== 1'b1) begin n_bad++; $display("FAIL fill_wen[%0d] got %b want 1", i, ifa.wen); end
         tick();
         e = 5'(i + 1);
         n_cmp++; if (ifa.wrptr_bin !== e) begin n_bad++; $display("FAIL fill_bin[%0d] got %0d want %0d", i, ifa.wrptr_bin, e); end
         n_cmp++; if (ifa.wrptr_gray !== (e ^ (e >> 1))) begin n_bad++; $display("FAIL fill_gray[%0d] got %b want %b", i, ifa.wrptr_gray, e ^ (e >> 1)); end
         n_cmp++; if (ifa.wr_count !== e) begin n_bad++; $display("FAIL fill_count[%0d] got %0d want %0d", i, ifa.wr_count, e); end
         n_cmp++; if (ifa.full !== (i == 15)) begin n_bad++; $display("FAIL fill_full[%0d] got %b want %b", i, ifa.full, (i == 15)); end
         n_cmp++; if (ifa.almost_full !== (i >= 11)) begin n_bad++; $display("FAIL fill_afull[%0d] got %b want %b", i, ifa.almost_full, (i >= 11)); end
      end
      n_cmp++; if (ifa.wrptr_bin !== 5'b10000) begin n_bad++; $display("FAIL fill_final_bin got %b want 10000", ifa.wrptr_bin); end
      n_cmp++; if (ifa.wen !== 1'b0) begin n_bad++; $display("FAIL fill_wen17 got %b want 0", ifa.wen); end
      n_cmp++; if (ifa.overflow !== 1'b0) begin n_bad++; $display("FAIL fill_no_ovf got %b want 0", ifa.overflow); end
      n_cmp++; if (ifb.full !== 1'b1) begin n_bad++; $display("FAIL fill_full_b got %b want 1", ifb.full); end
      ifa.afull_level = 5'd0;  #1;
      n_cmp++; if (ifa.almost_full !== 1'b0) begin n_bad++; $display("FAIL afull_disabled got %b want 0", ifa.almost_full); end
      ifa.afull_level = 5'd17; #1;
      n_cmp++; if (ifa.almost_full !== 1'b0) begin n_bad++; $display("FAIL afull_above_depth got %b want 0", ifa.almost_full); end
      ifa.afull_level = 5'd16; #1;
      n_cmp++; if (ifa.almost_full !== 1'b1) begin n_bad++; $display("FAIL afull_at_depth got %b want 1", ifa.almost_full); end
   endtask

   // push is still high while full from the fill test.
   task automatic test_overflow;
      tick();
      n_cmp++; if (ifa.overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set got %b want 1", ifa.overflow); end
      n_cmp++; if (ifa.wrptr_bin !== 5'd16) begin n_bad++; $display("FAIL ovf_hold_bin got %0d want 16", ifa.wrptr_bin); end
      ifa.clr_ovf = 1'b1;
      tick();
      n_cmp++; if (ifa.overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set_wins got %b want 1", ifa.overflow); end
      ifa.push = 1'b0;
      tick();
      n_cmp++; if (ifa.overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clear got %b want 0", ifa.overflow); end
      ifa.clr_ovf = 1'b0;
   endtask

   // Reader frees one slot; a push on the edge where full drops is still rejected.
   task automatic test_drain;
      ifa.rdptr_gray = 5'b00001;
      tick();
      n_cmp++; if (ifa.full !== 1'b1) begin n_bad++; $display("FAIL drain_a_edge1 got %b want 1", ifa.full); end
      n_cmp++; if (ifb.full !== 1'b1) begin n_bad++; $display("FAIL drain_b_edge1 got %b want 1", ifb.full); end
      ifa.push = 1'b1;
      tick();
      ifa.push = 1'b0;
      n_cmp++; if (ifa.full !== 1'b0) begin n_bad++; $display("FAIL drain_a_edge2 got %b want 0", ifa.full); end
      n_cmp++; if (ifa.wr_count !== 5'd15) begin n_bad++; $display("FAIL drain_a_count got %0d want 15", ifa.wr_count); end
      n_cmp++; if (ifa.wrptr_bin !== 5'd16) begin n_bad++; $display("FAIL drain_simul_bin got %0d want 16", ifa.wrptr_bin); end
      n_cmp++; if (ifa.overflow !== 1'b1) begin n_bad++; $display("FAIL drain_simul_ovf got %b want 1", ifa.overflow); end
      n_cmp++; if (ifb.full !== 1'b1) begin n_bad++; $display("FAIL drain_b_edge2 got %b want 1", ifb.full); end
      ifa.clr_ovf = 1'b1;
      tick();
      ifa.clr_ovf = 1'b0;
      n_cmp++; if (ifb.full !== 1'b0) begin n_bad++; $display("FAIL drain_b_edge3 got %b want 0", ifb.full); end
      n_cmp++; if (ifb.wr_count !== 5'd15) begin n_bad++; $display("FAIL drain_b_count got %0d want 15", ifb.wr_count); end
      n_cmp++; if (ifa.overflow !== 1'b0) begin n_bad++; $display("FAIL drain_ovf_clear got %b want 0", ifa.overflow); end
   endtask

   // Reader follows the writer one cycle behind across a pointer wrap.
   task automatic test_wrap;
      logic [4:0] exp_b, prev_g, prev_b;
      int wraps;
      wraps = 0;
      ifa.rdptr_gray = 5'b11000;
      repeat (3) tick();
      n_cmp++; if (ifa.wr_count !== 5'd0) begin n_bad++; $display("FAIL wrap_empty got %0d want 0", ifa.wr_count); end
      exp_b  = 5'd16;
      prev_g = 5'b11000;
      prev_b = 5'd16;
      for (int k = 0; k < 40; k++) begin
         ifa.push = 1'b1;
         tick();
         exp_b = exp_b + 5'd1;
         n_cmp++; if (ifa.wrptr_bin !== exp_b) begin n_bad++; $display("FAIL wrap_bin[%0d] got %0d want %0d", k, ifa.wrptr_bin, exp_b); end
         n_cmp++; if ($countones(prev_g ^ ifa.wrptr_gray) != 1) begin n_bad++; $display("FAIL wrap_gray_step[%0d] got %b want one bit from %b", k, ifa.wrptr_gray, prev_g); end
         n_cmp++; if ((ifa.full | ifb.full) !== 1'b0) begin n_bad++; $display("FAIL wrap_full[%0d] got %b want 0", k, ifa.full | ifb.full); end
         if (prev_b == 5'd31 && ifa.wrptr_bin == 5'd0) wraps++;
         prev_g = ifa.wrptr_gray;
         prev_b = ifa.wrptr_bin;
         ifa.rdptr_gray = ifa.wrptr_gray;
      end
      ifa.push = 1'b0;
      n_cmp++; if (wraps != 1) begin n_bad++; $display("FAIL wrap_count got %0d want 1", wraps); end
   endtask

   // Asynchronous reset dropped between edges with nine entries in flight.
   task automatic test_midreset;
      ifa.rdptr_gray = ifa.wrptr_gray;
      repeat (4) tick();
      ifa.push = 1'b1;
      repeat (9) tick();
      ifa.push = 1'b0;
      #1;
      n_cmp++; if (ifa.wr_count !== 5'd9) begin n_bad++; $display("FAIL mid_count9 got %0d want 9", ifa.wr_count); end
      #2;
      reset_L = 1'b0;
      #1;
      n_cmp++; if (ifa.wrptr_bin !== 5'd0) begin n_bad++; $display("FAIL mid_bin got %0d want 0", ifa.wrptr_bin); end
      n_cmp++; if (ifa.wrptr_gray !== 5'd0) begin n_bad++; $display("FAIL mid_gray got %0d want 0", ifa.wrptr_gray); end
      n_cmp++; if (ifa.wr_count !== 5'd0) begin n_bad++; $display("FAIL mid_count got %0d want 0", ifa.wr_count); end
      n_cmp++; if (ifa.waddr !== 4'd0) begin n_bad++; $display("FAIL mid_waddr got %0d want 0", ifa.waddr); end
      n_cmp++; if ({ifa.full, ifa.wen, ifa.overflow} !== 3'b000) begin n_bad++; $display("FAIL mid_flags got %b want 000", {ifa.full, ifa.wen, ifa.overflow}); end
      ifa.rdptr_gray = 5'd0;
      #3;
      reset_L = 1'b1;
      ifa.push = 1'b1;
      #1;
      n_cmp++; if (ifa.waddr !== 4'd0) begin n_bad++; $display("FAIL post_waddr got %0d want 0", ifa.waddr); end
      n_cmp++; if (ifa.wen !== 1'b1) begin n_bad++; $display("FAIL post_wen got %b want 1", ifa.wen); end
      tick();
      ifa.push = 1'b0;
      n_cmp++; if (ifa.wrptr_bin !== 5'd1) begin n_bad++; $display("FAIL post_bin got %0d want 1", ifa.wrptr_bin); end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_overflow();
      test_drain();
      test_wrap();
      test_midreset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/controller_wr_param.md
Name: controller_wr_param

Overview:
Parametrised write-side controller for the asynchronous FIFO. It runs entirely in the write clock domain and:
- owns the binary and Gray write pointers;
- synchronises the read-domain Gray pointer through a configurable-depth flop chain;
- produces full, programmable almost-full, fill count and a sticky overflow error.

It drives the dual-port RAM write port and feeds wrptr_gray to the read-side controller.

Parameters:
PTRWIDTH, 4, address width; FIFO depth DEPTH = 2^PTRWIDTH; pointers are PTRWIDTH+1 bits (extra wrap bit).
SYNC_STAGES, 2, flops in the rdptr_gray synchroniser; legal range 2..4.

Ports:
wclk  input  1  write-domain clock; all state updates on its rising edge.
reset_L  input  1  asynchronous, active-low reset.
push  input  1  write request for the current cycle.
clr_ovf  input  1  clears the sticky overflow flag.
afull_level  input  PTRWIDTH+1  almost-full threshold in entries; 0 disables almost_full.
rdptr_gray  input  PTRWIDTH+1  read pointer, Gray coded, from the read clock domain (asynchronous).
wen  output  1  RAM write enable (push & !full).
waddr  output  PTRWIDTH  RAM write address (wrptr_bin[PTRWIDTH-1:0]).
wrptr_bin  output  PTRWIDTH+1  binary write pointer.
wrptr_gray  output  PTRWIDTH+1  registered Gray write pointer, sent to the read domain.
wr_count  output  PTRWIDTH+1  fill level as seen by the write side, range 0..DEPTH.
full  output  1  FIFO full.
almost_full  output  1  wr_count >= afull_level (when afull_level != 0).
overflow  output  1  sticky: a push was attempted while full.

Behaviour:
- Reset (reset_L=0, asynchronous):
  - wrptr_bin, wrptr_gray, all synchroniser flops, and overflow go to 0.
  - Consequently wr_count=0, full=0, wen=0 and almost_full=0.
- Write acceptance:
  - wen = push & !full, combinational from the current registers.
  - On wen, wrptr_bin <= wrptr_bin+1 modulo 2^(PTRWIDTH+1); the carry is discarded and 2*DEPTH-1 wraps to 0.
- Gray pointer:
  - wrptr_gray <= bin2gray(next wrptr_bin), registered in the same edge as wrptr_bin.
  - The two are always consistent; exactly one bit of wrptr_gray changes per accepted write. wrptr_gray has no combinational path.
- Synchroniser:
  - rdptr_gray is captured through SYNC_STAGES flops, giving rdptr_sync.
  - rdptr_bin_s = gray2bin(rdptr_sync). The conversion is full width: bit PTRWIDTH is copied, and every bit i from PTRWIDTH-1 down to 0 is bit i+1 XOR gray bit i.
- Count: wr_count = (wrptr_bin - rdptr_bin_s) modulo 2^(PTRWIDTH+1), combinational.
- Full: full = 1 iff wr_count == DEPTH, equivalently MSBs differ and lower PTRWIDTH bits are equal.
- Almost-full:
  - almost_full = (afull_level != 0) && (wr_count >= afull_level).
  - afull_level > DEPTH means almost_full is never asserted.
- Latency:
  - An accepted push updates wrptr_bin, wr_count and full one edge later.
  - A read-pointer change at the input reaches full/wr_count after SYNC_STAGES wclk edges.
  - full is therefore pessimistic (may stay high after a read) but never optimistic.
- Overflow:
  - push & full sets overflow at the next edge; clr_ovf clears it.
  - If set and clear occur in the same cycle, set wins.
  - A rejected push has no other effect: pointers are held.
- Simultaneous events: push in the same cycle the synchronised read pointer advances out of full is evaluated against the pre-edge full; the push is rejected and flagged as overflow.
- Reset mid-operation: all state returns to 0 immediately. The read side must also be reset; behaviour with only one side in reset is undefined.

Decomposition:
- Package fifo_pkg holds:
  - functions bin2gray and gray2bin, parametrised on width;
  - constant SYNC_STAGES_MIN = 2.
- One sub-module, sync_ptr:
  - a width- and stage-parametrised flop chain with asynchronous active-low reset;
  - reused by the read-side controller for wrptr_gray.

Test Plan:
1. Fill: PTRWIDTH=4, rdptr_gray held 0, push for 16 cycles -> wrptr_bin=5'b10000, wr_count=16, full=1 after 16th edge; wen low on 17th push.
2. Overflow: with full=1, push one cycle -> overflow=1 next edge, wrptr_bin stays 16; pulse clr_ovf together with push -> overflow stays 1; clr_ovf alone -> 0.
3. Drain latency: from full, drive rdptr_gray=5'b00001 (binary 1) -> full stays 1 for 1 edge and drops after 2nd edge (SYNC_STAGES=2), wr_count=15; repeat with SYNC_STAGES=3 -> drops after 3rd edge.
4. Wrap: reader tracks writer (rdptr_gray = wrptr_gray delayed) for 40 pushes -> wrptr_bin wraps 31->0 once, every wrptr_gray step changes exactly one bit, full never asserts.
5. Almost-full: afull_level=12, fill from empty -> almost_full rises when wr_count reaches 12; afull_level=0 -> never asserts.
6. Mid-op reset: at wr_count=9, drop reset_L asynchronously between edges -> all outputs 0 immediately; first push after release writes waddr=0.
